// File: rtl/udp_line_scheduler_pkg.sv
// Shared types and sizing for the UDP line scheduler: FSM state encoding,
// default packet/FIFO geometry and statistics counter widths.
package eth_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } sched_state_t;

    localparam int LINE_BYTES_DEFAULT = 2562;
    localparam int FIFO_DEPTH_DEFAULT = 8192;
    localparam int LINE_CNT_W         = 16;
    localparam int PKT_TOTAL_W        = 32;
    localparam int USEDW_W            = 13;
    localparam int TIMER_W            = 17;

endpackage

// File: rtl/udp_line_scheduler_if.sv
// Control/status bundle between the scheduler, the FIFO formatter side and
// the UDP send engine. master = scheduler, slave = surrounding logic.
interface udp_line_scheduler_if;
    import eth_sched_pkg::*;

    logic                   enable;
    logic                   flush;
    logic [USEDW_W-1:0]     fifo_usedw;
    logic                   tx_done;
    logic                   clr_stat;
    logic                   tx_start;
    logic [15:0]            data_length;
    logic [LINE_CNT_W-1:0]  line_cnt;
    logic [PKT_TOTAL_W-1:0] pkt_total;
    logic                   timeout_err;
    logic                   overflow;
    logic                   busy;

    modport master (
        input  enable, flush, fifo_usedw, tx_done, clr_stat,
        output tx_start, data_length, line_cnt, pkt_total, timeout_err, overflow, busy
    );

    modport slave (
        output enable, flush, fifo_usedw, tx_done, clr_stat,
        input  tx_start, data_length, line_cnt, pkt_total, timeout_err, overflow, busy
    );

endinterface

// File: rtl/udp_line_scheduler_cycle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module cycle_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    // Holds at zero; callers reload before every use, so no reset is needed.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/udp_line_scheduler.sv
// Paces UDP line packets: starts one packet per buffered line, waits for
// completion or timeout, then enforces an inter-packet gap.
module udp_line_scheduler
    import eth_sched_pkg::*;
#(
    parameter int LINE_BYTES     = LINE_BYTES_DEFAULT,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    udp_line_scheduler_if.master  bus
);

    localparam logic [USEDW_W-1:0] LINE_THR = USEDW_W'(LINE_BYTES);
    localparam logic [USEDW_W-1:0] FULL_THR = USEDW_W'(FIFO_DEPTH - 1);
    localparam int                 GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_EFF - 1);
    // The START cycle counts toward the budget, so WAIT_DONE lasts TIMEOUT_CYCLES-1 clocks.
    localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'((TIMEOUT_CYCLES < 2) ? 0 : TIMEOUT_CYCLES - 2);

    sched_state_t state;
    logic         gap_tc;
    logic         to_tc;
    logic         line_ready;
    logic         fifo_full;

    assign line_ready       = (bus.fifo_usedw >= LINE_THR);
    assign fifo_full        = (bus.fifo_usedw >= FULL_THR);
    assign bus.data_length  = 16'(LINE_BYTES);

    cycle_timer #(.W(TIMER_W)) u_gap_timer (
        .clk      (Clk),
        .load     (state == ST_WAIT_DONE),
        .load_val (GAP_LOAD),
        .en       (state == ST_GAP),
        .tc       (gap_tc)
    );

    cycle_timer #(.W(TIMER_W)) u_timeout_timer (
        .clk      (Clk),
        .load     (state == ST_START),
        .load_val (TO_LOAD),
        .en       (state == ST_WAIT_DONE),
        .tc       (to_tc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state           <= ST_IDLE;
            bus.tx_start    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.line_cnt    <= '0;
            bus.pkt_total   <= '0;
            bus.timeout_err <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            if (bus.clr_stat) begin
                bus.timeout_err <= 1'b0;
            end

            if (fifo_full) begin
                bus.overflow <= 1'b1;
            end else if (bus.clr_stat) begin
                bus.overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!bus.flush && bus.enable && line_ready) begin
                        state        <= ST_START;
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    bus.tx_start <= 1'b0;
                    if (bus.flush) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state    <= ST_WAIT_DONE;
                    end
                end
                // A completion on the timeout edge still counts as a good packet.
                ST_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state         <= ST_GAP;
                        bus.line_cnt  <= bus.line_cnt + 1'b1;
                        bus.pkt_total <= bus.pkt_total + 1'b1;
                    end else if (to_tc) begin
                        state           <= ST_GAP;
                        bus.timeout_err <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (bus.flush || gap_tc) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.tx_start <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase

            // Frame restart overrides any completion counted this cycle.
            if (bus.flush) begin
                bus.line_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_udp_line_scheduler.sv
// Bench for udp_line_scheduler: directed scenarios plus a randomized run
// against an edge-counting behavioural model.
module tb_udp_line_scheduler;
    import eth_sched_pkg::*;

    localparam int LB = 2562;
    localparam int FD = 8192;
    localparam int G  = 1000;
    localparam int T  = 150;

    logic Clk = 1'b0;
    logic Rst_n;
    always #4 Clk = ~Clk;

    udp_line_scheduler_if bus();

    udp_line_scheduler #(
        .LINE_BYTES     (LB),
        .FIFO_DEPTH     (FD),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 start issued, 2 in flight, 3 gap; deadlines kept as absolute edge numbers.
    int          cyc = 0;
    int          m_phase = 0;
    int          start_edge = 0;
    int          gap_end = 0;
    logic [15:0] m_line = '0;
    logic [31:0] m_pkt = '0;
    logic        m_tout = 1'b0;
    logic        m_ovf = 1'b0;

    always @(posedge Clk) begin : model
        int          c, ph, se, ge;
        logic [15:0] ln;
        logic [31:0] pk;
        logic        to, ov, tset;
        c = cyc + 1; ph = m_phase; se = start_edge; ge = gap_end;
        ln = m_line; pk = m_pkt; to = m_tout; ov = m_ovf; tset = 1'b0;
        if (!Rst_n) begin
            ph = 0; ln = '0; pk = '0; to = 1'b0; ov = 1'b0;
        end else begin
            case (ph)
                0: if (!bus.flush && bus.enable && (int'(bus.fifo_usedw) >= LB)) begin
                       ph = 1; se = c;
                   end
                1: ph = bus.flush ? 0 : 2;
                2: if (bus.tx_done) begin
                       ph = 3; ge = c + G; ln = ln + 1'b1; pk = pk + 1'b1;
                   end else if (c == se + T) begin
                       ph = 3; ge = c + G; tset = 1'b1;
                   end
                default: if (bus.flush || c == ge) ph = 0;
            endcase
            if (bus.flush) ln = '0;
            if (tset) to = 1'b1;
            else if (bus.clr_stat) to = 1'b0;
            if (int'(bus.fifo_usedw) >= FD - 1) ov = 1'b1;
            else if (bus.clr_stat) ov = 1'b0;
        end
        cyc <= c; m_phase <= ph; start_edge <= se; gap_end <= ge;
        m_line <= ln; m_pkt <= pk; m_tout <= to; m_ovf <= ov;
    end

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        @(negedge Clk);
        bus.tx_done = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.enable = 1'b1; bus.fifo_usedw = 13'(LB);
        bus.flush = 1'b0; bus.tx_done = 1'b0; bus.clr_stat = 1'b0;
        checks++;
        if (bus.data_length !== 16'(LB)) begin
            errors++; $display("FAIL reset_len_async: data_length=%0d expected %0d", bus.data_length, LB);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if ({bus.tx_start, bus.busy, bus.timeout_err, bus.overflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: start/busy/tout/ovf=%b expected 0000",
                {bus.tx_start, bus.busy, bus.timeout_err, bus.overflow});
        end
        checks++;
        if (bus.line_cnt !== 16'd0 || bus.pkt_total !== 32'd0) begin
            errors++; $display("FAIL reset_counts: line=%0d pkt=%0d expected 0 0", bus.line_cnt, bus.pkt_total);
        end
        checks++;
        if (bus.data_length !== 16'(LB)) begin
            errors++; $display("FAIL reset_len: data_length=%0d expected %0d", bus.data_length, LB);
        end
        bus.fifo_usedw = '0;
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic_send();
        int s_cnt;
        bus.enable = 1'b1; bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_start: tx_start=%b busy=%b expected 1 1", bus.tx_start, bus.busy);
        end
        s_cnt = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge Clk);
            if (bus.tx_start) s_cnt++;
        end
        checks++;
        if (s_cnt != 0) begin
            errors++; $display("FAIL basic_single_pulse: extra starts=%0d expected 0", s_cnt);
        end
        pulse_done();
        checks++;
        if (bus.line_cnt !== 16'd1 || bus.pkt_total !== 32'd1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_count: line=%0d pkt=%0d busy=%b expected 1 1 1",
                bus.line_cnt, bus.pkt_total, bus.busy);
        end
        s_cnt = 0;
        for (int i = 1; i <= G; i++) begin
            @(negedge Clk);
            if (bus.tx_start) s_cnt++;
        end
        checks++;
        if (s_cnt != 0) begin
            errors++; $display("FAIL basic_gap: starts during gap=%0d expected 0", s_cnt);
        end
        @(negedge Clk);
        checks++;
        if (bus.tx_start !== 1'b1) begin
            errors++; $display("FAIL basic_next_start: tx_start=%b expected 1", bus.tx_start);
        end
        bus.fifo_usedw = '0;
        repeat (3) @(negedge Clk);
        pulse_done();
        checks++;
        if (bus.line_cnt !== 16'd2 || bus.pkt_total !== 32'd2) begin
            errors++; $display("FAIL basic_second: line=%0d pkt=%0d expected 2 2", bus.line_cnt, bus.pkt_total);
        end
        repeat (G + 1) @(negedge Clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_threshold();
        int s_cnt = 0;
        bus.fifo_usedw = 13'(LB - 1);
        for (int i = 0; i < 5000; i++) begin
            @(negedge Clk);
            if (bus.tx_start || bus.busy) s_cnt++;
        end
        checks++;
        if (s_cnt != 0) begin
            errors++; $display("FAIL thr_below: active cycles=%0d expected 0", s_cnt);
        end
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        checks++;
        if (bus.tx_start !== 1'b1) begin
            errors++; $display("FAIL thr_at: tx_start=%b expected 1", bus.tx_start);
        end
        bus.fifo_usedw = '0;
        repeat (2) @(negedge Clk);
        pulse_done();
        checks++;
        if (bus.pkt_total !== 32'd3) begin
            errors++; $display("FAIL thr_count: pkt=%0d expected 3", bus.pkt_total);
        end
        repeat (G + 1) @(negedge Clk);
    endtask

    task automatic test_timeout();
        int first_k = 0;
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.fifo_usedw = '0;
        for (int k = 1; k <= T + 5; k++) begin
            @(negedge Clk);
            if (bus.timeout_err && first_k == 0) first_k = k;
        end
        checks++;
        if (first_k != T) begin
            errors++; $display("FAIL tout_edge: timeout_err rose on edge %0d expected %0d", first_k, T);
        end
        checks++;
        if (bus.line_cnt !== 16'd3 || bus.pkt_total !== 32'd3) begin
            errors++; $display("FAIL tout_counts: line=%0d pkt=%0d expected 3 3", bus.line_cnt, bus.pkt_total);
        end
        repeat (G) @(negedge Clk);
        bus.clr_stat = 1'b1;
        @(negedge Clk);
        bus.clr_stat = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL tout_clear: timeout_err=%b busy=%b expected 0 0", bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_flush();
        int s_cnt = 0;
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.fifo_usedw = '0;
        repeat (4) @(negedge Clk);
        pulse_done();
        repeat (10) @(negedge Clk);
        bus.flush = 1'b1;
        @(negedge Clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.line_cnt !== 16'd0 || bus.pkt_total !== 32'd4) begin
            errors++; $display("FAIL flush_gap: busy=%b line=%0d pkt=%0d expected 0 0 4",
                bus.busy, bus.line_cnt, bus.pkt_total);
        end
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.flush = 1'b1; bus.fifo_usedw = '0;
        @(negedge Clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL flush_start: busy=%b tx_start=%b expected 0 0", bus.busy, bus.tx_start);
        end
        bus.fifo_usedw = 13'(LB); bus.flush = 1'b1;
        @(negedge Clk);
        bus.flush = 1'b0; bus.fifo_usedw = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (bus.tx_start || bus.busy) s_cnt++;
        end
        checks++;
        if (s_cnt != 0) begin
            errors++; $display("FAIL flush_idle: active cycles=%0d expected 0", s_cnt);
        end
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.fifo_usedw = '0;
        repeat (3) @(negedge Clk);
        bus.flush = 1'b1;
        @(negedge Clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.line_cnt !== 16'd0) begin
            errors++; $display("FAIL flush_wait: busy=%b line=%0d expected 1 0", bus.busy, bus.line_cnt);
        end
        repeat (2) @(negedge Clk);
        pulse_done();
        checks++;
        if (bus.line_cnt !== 16'd1 || bus.pkt_total !== 32'd5 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL flush_wait_done: line=%0d pkt=%0d busy=%b expected 1 5 1",
                bus.line_cnt, bus.pkt_total, bus.busy);
        end
        repeat (G + 1) @(negedge Clk);
        bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.fifo_usedw = '0;
        repeat (3) @(negedge Clk);
        bus.flush = 1'b1; bus.tx_done = 1'b1;
        @(negedge Clk);
        bus.flush = 1'b0; bus.tx_done = 1'b0;
        checks++;
        if (bus.line_cnt !== 16'd0 || bus.pkt_total !== 32'd6) begin
            errors++; $display("FAIL flush_with_done: line=%0d pkt=%0d expected 0 6", bus.line_cnt, bus.pkt_total);
        end
        repeat (G + 1) @(negedge Clk);
    endtask

    task automatic test_coincidence();
        bus.enable = 1'b0; bus.fifo_usedw = 13'(FD - 2);
        @(negedge Clk);
        checks++;
        if (bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ovf_below: overflow=%b busy=%b expected 0 0", bus.overflow, bus.busy);
        end
        bus.fifo_usedw = 13'(FD - 1);
        @(negedge Clk);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: overflow=%b expected 1", bus.overflow);
        end
        bus.clr_stat = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set_wins: overflow=%b expected 1", bus.overflow);
        end
        bus.fifo_usedw = '0;
        @(negedge Clk);
        bus.clr_stat = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: overflow=%b expected 0", bus.overflow);
        end
        bus.enable = 1'b1; bus.fifo_usedw = 13'(LB);
        @(negedge Clk);
        bus.fifo_usedw = '0;
        repeat (T - 1) @(negedge Clk);
        pulse_done();
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.pkt_total !== 32'd7 || bus.line_cnt !== 16'd1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL tout_with_done: tout=%b pkt=%0d line=%0d busy=%b expected 0 7 1 1",
                bus.timeout_err, bus.pkt_total, bus.line_cnt, bus.busy);
        end
        repeat (G + 1) @(negedge Clk);
        bus.fifo_usedw = 13'(FD - 1);
        @(negedge Clk);
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        checks++;
        if ({bus.tx_start, bus.busy, bus.timeout_err, bus.overflow} !== 4'b0000 ||
            bus.line_cnt !== 16'd0 || bus.pkt_total !== 32'd0 || bus.data_length !== 16'(LB)) begin
            errors++; $display("FAIL reset_in_wait: start/busy/tout/ovf=%b line=%0d pkt=%0d len=%0d expected 0000 0 0 %0d",
                {bus.tx_start, bus.busy, bus.timeout_err, bus.overflow}, bus.line_cnt, bus.pkt_total, bus.data_length, LB);
        end
        @(negedge Clk);
        checks++;
        if (bus.tx_start !== 1'b0) begin
            errors++; $display("FAIL reset_no_start: tx_start=%b expected 0", bus.tx_start);
        end
        bus.fifo_usedw = '0;
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 8000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      bus.fifo_usedw = 13'($urandom_range(LB, 4000));
            else if (r < 85) bus.fifo_usedw = 13'($urandom_range(0, LB - 1));
            else if (r < 95) bus.fifo_usedw = 13'($urandom_range(LB - 1, LB));
            else             bus.fifo_usedw = 13'($urandom_range(FD - 2, FD - 1));
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.tx_done  = ($urandom_range(0, 29) == 0);
            bus.flush    = ($urandom_range(0, 199) == 0);
            bus.clr_stat = ($urandom_range(0, 99) == 0);
            Rst_n        = ($urandom_range(0, 999) != 0);
            @(negedge Clk);
            checks++;
            if (bus.tx_start !== (m_phase == 1) || bus.busy !== (m_phase != 0)) begin
                errors++; $display("FAIL rand_ctrl[%0d]: tx_start=%b busy=%b expected %b %b",
                    i, bus.tx_start, bus.busy, (m_phase == 1), (m_phase != 0));
            end
            checks++;
            if (bus.line_cnt !== m_line || bus.pkt_total !== m_pkt) begin
                errors++; $display("FAIL rand_counts[%0d]: line=%0d pkt=%0d expected %0d %0d",
                    i, bus.line_cnt, bus.pkt_total, m_line, m_pkt);
            end
            checks++;
            if (bus.timeout_err !== m_tout || bus.overflow !== m_ovf) begin
                errors++; $display("FAIL rand_flags[%0d]: tout=%b ovf=%b expected %b %b",
                    i, bus.timeout_err, bus.overflow, m_tout, m_ovf);
            end
        end
        bus.tx_done = 1'b0; bus.flush = 1'b0; bus.clr_stat = 1'b0; Rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_send();
        test_threshold();
        test_timeout();
        test_flush();
        test_coincidence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
